gpio_plus: RTL and testbench

Parametrised next-generation GPIO controller on the peripheral bus (sysio).
- Adds over the previous GPIO: configurable pin and interrupt-line counts, per-pin input synchroniser with programmable debounce, atomic set/clear of output data, and sticky interrupt-pending bits with write-1-to-clear.
- Keeps the existing register offsets and the input/latch/push-pull/open-drain modes.

---
 rtl/gpio_plus_pkg.sv | 34 +++
 rtl/gpio_in_filter.sv | 56 +++++
 rtl/gpio_plus.sv | 164 ++++++++++++++++
 tb/tb_gpio_plus.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_plus_pkg.sv
// gpio_plus shared definitions: register offsets, TAI edge-mode encodings
// and the byte-enable expansion helper.
// Build switch: define GPIO_DEBOUNCE_EN to get the per-pin debounce counters
// and a writable DBC register; otherwise inputs follow the synchroniser directly.
package gpio_plus_pkg;

  localparam logic [7:0] GPIO_DIN  = 8'h00;
  localparam logic [7:0] GPIO_OPT  = 8'h04;
  localparam logic [7:0] GPIO_OEC  = 8'h08;
  localparam logic [7:0] GPIO_OMD  = 8'h0C;
  localparam logic [7:0] GPIO_TAI  = 8'h10;
  localparam logic [7:0] GPIO_OSET = 8'h14;
  localparam logic [7:0] GPIO_OCLR = 8'h18;
  localparam logic [7:0] GPIO_IPND = 8'h1C;
  localparam logic [7:0] GPIO_DBC  = 8'h20;

  typedef enum logic [1:0] {
    TAI_OFF  = 2'b00,
    TAI_RISE = 2'b01,
    TAI_FALL = 2'b10,
    TAI_BOTH = 2'b11
  } tai_mode_e;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: one pin's input path. SYNC_STG-deep synchroniser followed
// by a debounce filter: filt only moves to a new level once that level has
// been seen for dbc+1 consecutive cycles. With dbc tied to zero the counter
// never leaves zero and filt simply follows the synchroniser one edge later.
module gpio_in_filter #(
  parameter int SYNC_STG = 2,
  parameter int DBC_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pin_in,
  input  logic [DBC_W-1:0] dbc,
  output logic             filt
);

  logic [SYNC_STG-1:0] sync_reg;
  logic                sync;
  logic                filt_reg, filt_next;
  logic [DBC_W-1:0]    cnt_reg, cnt_next;

  assign sync = sync_reg[SYNC_STG-1];

  // Synchroniser shift chain for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STG-2:0], pin_in};
  end

  // Debounce decision; >= so a threshold lowered mid-count resolves at once.
  always_comb begin
    filt_next = filt_reg;
    cnt_next  = cnt_reg;
    if (sync == filt_reg) begin
      cnt_next = '0;
    end else if (cnt_reg >= dbc) begin
      filt_next = sync;
      cnt_next  = '0;
    end else begin
      cnt_next = cnt_reg + DBC_W'(1);
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      filt_reg <= filt_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign filt = filt_reg;

endmodule

// File: rtl/gpio_plus.sv
// gpio_plus: parametrised GPIO controller. Byte-masked register writes,
// atomic OSET/OCLR, input/latch/push-pull/open-drain modes, edge interrupts
// with sticky write-1-to-clear pending bits, registered one-cycle reads.
// Build switch: GPIO_DEBOUNCE_EN enables the DBC register and debounce counters.
module gpio_plus
  import gpio_plus_pkg::*;
#(
  parameter int GPIO_W   = 32,
  parameter int IRQ_W    = 16,
  parameter int SYNC_STG = 2,
  parameter int DBC_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        waddr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  input  logic              we_i,
  input  logic [7:0]        raddr_i,
  input  logic              rd_i,
  output logic [31:0]       data_o,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [IRQ_W-1:0]  gpio_irq,
  input  logic [GPIO_W-1:0] gpio_in
);

  localparam int IRQ_BASE = GPIO_W - IRQ_W;
  localparam int TAI_W    = 2 * IRQ_W;

  logic [GPIO_W-1:0] opt_reg, opt_next;
  logic [GPIO_W-1:0] oec_reg, oec_next;
  logic [GPIO_W-1:0] omd_reg, omd_next;
  logic [GPIO_W-1:0] din_reg, din_next;
  logic [GPIO_W-1:0] filt;
  logic [TAI_W-1:0]  tai_reg, tai_next;
  logic [IRQ_W-1:0]  ipnd_reg, ipnd_next;
  logic [IRQ_W-1:0]  ipnd_clr, irq_set;
  logic [IRQ_W-1:0]  filt_irq, filt_d_reg, rise_reg, fall_reg;
  logic [31:0]       wr_mask, wr_bits, rd_data;
  logic [DBC_W-1:0]  dbc_val;

  assign wr_mask = byte_mask(sel_i);
  assign wr_bits = data_i & wr_mask;

`ifdef GPIO_DEBOUNCE_EN
  logic [DBC_W-1:0] dbc_reg;

  // Debounce threshold register, byte-masked.
  always_ff @(posedge clk) begin
    if (rst)
      dbc_reg <= '0;
    else if (we_i && waddr_i == GPIO_DBC)
      dbc_reg <= (dbc_reg & ~wr_mask[DBC_W-1:0]) | wr_bits[DBC_W-1:0];
  end

  assign dbc_val = dbc_reg;
`else
  // Zero threshold: the filter counters collapse to constants.
  assign dbc_val = '0;
`endif

  genvar gi;

  // Per-pin input path and DIN update (held while the pin is in latch mode).
  for (gi = 0; gi < GPIO_W; gi++) begin : g_pin
    gpio_in_filter #(
      .SYNC_STG(SYNC_STG),
      .DBC_W   (DBC_W)
    ) u_filter (
      .clk   (clk),
      .rst   (rst),
      .pin_in(gpio_in[gi]),
      .dbc   (dbc_val),
      .filt  (filt[gi])
    );
    assign din_next[gi] = (!oec_reg[gi] && omd_reg[gi]) ? din_reg[gi] : filt[gi];
  end

  assign filt_irq = filt[GPIO_W-1 -: IRQ_W];

  // Qualify each line's registered edge flags with its TAI mode.
  for (gi = 0; gi < IRQ_W; gi++) begin : g_irq
    tai_mode_e mode;
    assign mode = tai_mode_e'(tai_reg[2*gi +: 2]);
    assign irq_set[gi] = (rise_reg[gi] && (mode == TAI_RISE || mode == TAI_BOTH)) ||
                         (fall_reg[gi] && (mode == TAI_FALL || mode == TAI_BOTH));
  end

  // Control register write decode.
  always_comb begin
    opt_next = opt_reg;
    oec_next = oec_reg;
    omd_next = omd_reg;
    tai_next = tai_reg;
    if (we_i) begin
      case (waddr_i)
        GPIO_OPT:  opt_next = (opt_reg & ~wr_mask[GPIO_W-1:0]) | wr_bits[GPIO_W-1:0];
        GPIO_OEC:  oec_next = (oec_reg & ~wr_mask[GPIO_W-1:0]) | wr_bits[GPIO_W-1:0];
        GPIO_OMD:  omd_next = (omd_reg & ~wr_mask[GPIO_W-1:0]) | wr_bits[GPIO_W-1:0];
        GPIO_TAI:  tai_next = (tai_reg & ~wr_mask[TAI_W-1:0]) | wr_bits[TAI_W-1:0];
        GPIO_OSET: opt_next = opt_reg | wr_bits[GPIO_W-1:0];
        GPIO_OCLR: opt_next = opt_reg & ~wr_bits[GPIO_W-1:0];
        default:   ;
      endcase
    end
  end

  // Sticky pending bits: a new event in the same cycle beats a W1C.
  assign ipnd_clr  = (we_i && waddr_i == GPIO_IPND) ? wr_bits[IRQ_W-1:0] : '0;
  assign ipnd_next = (ipnd_reg & ~ipnd_clr) | irq_set;

  // Register file, DIN capture and edge-detect pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      opt_reg    <= '0;
      oec_reg    <= '0;
      omd_reg    <= '0;
      tai_reg    <= '0;
      din_reg    <= '0;
      ipnd_reg   <= '0;
      filt_d_reg <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
    end else begin
      opt_reg    <= opt_next;
      oec_reg    <= oec_next;
      omd_reg    <= omd_next;
      tai_reg    <= tai_next;
      din_reg    <= din_next;
      ipnd_reg   <= ipnd_next;
      filt_d_reg <= filt_irq;
      rise_reg   <= filt_irq & ~filt_d_reg;
      fall_reg   <= ~filt_irq & filt_d_reg;
    end
  end

  // Read mux; write-only and unmapped offsets return zero.
  always_comb begin
    rd_data = '0;
    case (raddr_i)
      GPIO_DIN:  rd_data = 32'(din_reg);
      GPIO_OPT:  rd_data = 32'(opt_reg);
      GPIO_OEC:  rd_data = 32'(oec_reg);
      GPIO_OMD:  rd_data = 32'(omd_reg);
      GPIO_TAI:  rd_data = 32'(tai_reg);
      GPIO_IPND: rd_data = 32'(ipnd_reg);
      GPIO_DBC:  rd_data = 32'(dbc_val);
      default:   rd_data = '0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (rst)       data_o <= '0;
    else if (rd_i) data_o <= rd_data;
  end

  // Pin drivers: push-pull when OEC=1/OMD=0, open-drain when both set.
  assign gpio_oe  = oec_reg & ~(omd_reg & opt_reg);
  assign gpio_out = oec_reg & ~omd_reg & opt_reg;
  assign gpio_irq = ipnd_reg;

endmodule

// File: tb/tb_gpio_plus.sv
// tb_gpio_plus: directed-vector bench for gpio_plus with hand-computed
// expectations; adapts debounce expectations to GPIO_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_gpio_plus;
  import gpio_plus_pkg::*;

  localparam int GPIO_W   = 32;
  localparam int IRQ_W    = 16;
  localparam int SYNC_STG = 2;
  localparam int DBC_W    = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DBC_EFF = 3;
  localparam logic [31:0] DBC_RB = 32'd3;
  localparam logic [31:0] SHORT_SEEN = 32'd0;
`else
  localparam int DBC_EFF = 0;
  localparam logic [31:0] DBC_RB = 32'd0;
  localparam logic [31:0] SHORT_SEEN = 32'd1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        waddr_i, raddr_i;
  logic [31:0]       data_i;
  logic [3:0]        sel_i;
  logic              we_i, rd_i;
  logic [31:0]       data_o;
  logic [GPIO_W-1:0] gpio_oe, gpio_out, gpio_in;
  logic [IRQ_W-1:0]  gpio_irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd_val;
  logic [31:0] seen, first;

  gpio_plus #(
    .GPIO_W(GPIO_W), .IRQ_W(IRQ_W), .SYNC_STG(SYNC_STG), .DBC_W(DBC_W)
  ) dut (
    .clk(clk), .rst(rst), .waddr_i(waddr_i), .data_i(data_i), .sel_i(sel_i),
    .we_i(we_i), .raddr_i(raddr_i), .rd_i(rd_i), .data_o(data_o),
    .gpio_oe(gpio_oe), .gpio_out(gpio_out), .gpio_irq(gpio_irq), .gpio_in(gpio_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic bus_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] sel);
    @(negedge clk);
    waddr_i = addr; data_i = data; sel_i = sel; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0; sel_i = 4'h0;
  endtask

  task automatic bus_rd(input logic [7:0] addr, output logic [31:0] data);
    @(negedge clk);
    raddr_i = addr; rd_i = 1'b1;
    @(negedge clk);
    rd_i = 1'b0;
    data = data_o;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; waddr_i = '0; raddr_i = '0; data_i = '0; sel_i = '0;
    we_i = 1'b0; rd_i = 1'b0; gpio_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_data_o", data_o, 32'h0);
    check("rst_oe", gpio_oe, 32'h0);
    check("rst_out", gpio_out, 32'h0);
    check("rst_irq", 32'(gpio_irq), 32'h0);
    bus_rd(GPIO_OPT, rd_val); check("rst_opt", rd_val, 32'h0);

    // Atomic output updates and byte masks
    bus_wr(GPIO_OPT, 32'h0000_00F0, 4'hF);
    bus_wr(GPIO_OSET, 32'h0000_000F, 4'b0001);
    bus_wr(GPIO_OCLR, 32'h0000_0030, 4'b0001);
    bus_rd(GPIO_OPT, rd_val); check("opt_set_clr", rd_val, 32'h0000_00CF);
    bus_wr(GPIO_OSET, 32'h0000_0100, 4'b0001);
    bus_rd(GPIO_OPT, rd_val); check("oset_masked", rd_val, 32'h0000_00CF);
    bus_wr(GPIO_OPT, 32'hAABB_CCDD, 4'b0101);
    bus_rd(GPIO_OPT, rd_val); check("opt_bytemask", rd_val, 32'h00BB_00DD);
    bus_rd(GPIO_OSET, rd_val); check("rd_oset_zero", rd_val, 32'h0);
    bus_rd(GPIO_OPT, rd_val);
    bus_rd(8'h40, rd_val); check("rd_unmapped", rd_val, 32'h0);
    bus_rd(GPIO_OPT, rd_val);
    @(negedge clk); raddr_i = GPIO_OEC;
    idle(2);
    check("rd_hold", data_o, 32'h00BB_00DD);

    // Open-drain and push-pull on pin 3
    bus_wr(GPIO_OEC, 32'h8, 4'hF);
    bus_wr(GPIO_OMD, 32'h8, 4'hF);
    bus_wr(GPIO_OCLR, 32'h8, 4'b0001);
    check("od_low_oe", gpio_oe, 32'h8);
    check("od_low_out", gpio_out, 32'h0);
    bus_wr(GPIO_OSET, 32'h8, 4'b0001);
    check("od_high_oe", gpio_oe, 32'h0);
    bus_wr(GPIO_OMD, 32'h0, 4'hF);
    check("pp_oe", gpio_oe, 32'h8);
    check("pp_out", gpio_out, 32'h8);
    bus_wr(GPIO_OEC, 32'h0, 4'hF);

    // Debounce on pin 5
    bus_wr(GPIO_DBC, 32'h3, 4'hF);
    bus_rd(GPIO_DBC, rd_val); check("dbc_readback", rd_val, DBC_RB);
    @(negedge clk); gpio_in[5] = 1'b1; raddr_i = GPIO_DIN; rd_i = 1'b1;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) gpio_in[5] = 1'b0;
      if (data_o[5]) seen = 1;
    end
    check("dbc_short_pulse", seen, SHORT_SEEN);
    @(negedge clk); gpio_in[5] = 1'b1;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4) gpio_in[5] = 1'b0;
      if (data_o[5] && first == 0) first = k;
    end
    rd_i = 1'b0;
    check("dbc_long_latency", first, 32'(SYNC_STG + DBC_EFF + 3));

    // Interrupts on line 0 (pin 16)
    bus_wr(GPIO_DBC, 32'h0, 4'hF);
    bus_wr(GPIO_TAI, 32'h3, 4'hF);
    @(negedge clk); gpio_in[16] = 1'b1;
    for (int k = 1; k <= SYNC_STG + 3; k++) begin
      @(negedge clk);
      if (k == SYNC_STG + 2) check("irq_rise_early", 32'(gpio_irq), 32'h0);
    end
    check("irq_rise", 32'(gpio_irq), 32'h1);
    idle(3);
    @(negedge clk); gpio_in[16] = 1'b0;
    repeat (SYNC_STG + 2) @(negedge clk);
    waddr_i = GPIO_IPND; data_i = 32'h1; sel_i = 4'hF; we_i = 1'b1;
    @(negedge clk); we_i = 1'b0; sel_i = 4'h0;
    check("irq_set_beats_w1c", 32'(gpio_irq), 32'h1);
    bus_wr(GPIO_IPND, 32'h1, 4'hF);
    check("irq_w1c", 32'(gpio_irq), 32'h0);
    bus_wr(GPIO_TAI, 32'h0, 4'hF);
    @(negedge clk); gpio_in[16] = 1'b1;
    idle(10);
    check("tai_off_no_set", 32'(gpio_irq), 32'h0);
    bus_wr(GPIO_TAI, 32'h3, 4'hF);
    @(negedge clk); gpio_in[16] = 1'b0;
    idle(10);
    check("irq_fall", 32'(gpio_irq), 32'h1);
    bus_wr(GPIO_TAI, 32'h0, 4'hF);
    bus_rd(GPIO_IPND, rd_val); check("tai_off_keeps_ipnd", rd_val, 32'h1);
    bus_wr(GPIO_IPND, 32'hFFFF, 4'hF);
    bus_rd(GPIO_IPND, rd_val); check("ipnd_cleared", rd_val, 32'h0);

    // Latch mode on pin 2
    @(negedge clk); gpio_in[2] = 1'b1;
    idle(10);
    bus_rd(GPIO_DIN, rd_val); check("latch_din_high", rd_val & 32'h4, 32'h4);
    bus_wr(GPIO_OMD, 32'h4, 4'hF);
    @(negedge clk); gpio_in[2] = 1'b0;
    idle(10);
    bus_rd(GPIO_DIN, rd_val); check("latch_hold", rd_val & 32'h4, 32'h4);
    bus_wr(GPIO_OMD, 32'h0, 4'hF);
    idle(2);
    bus_rd(GPIO_DIN, rd_val); check("latch_release", rd_val & 32'h4, 32'h0);

    // Reset in the middle of traffic
    bus_wr(GPIO_OPT, 32'hFFFF_FFFF, 4'hF);
    bus_wr(GPIO_OEC, 32'hFFFF_FFFF, 4'hF);
    bus_wr(GPIO_TAI, 32'h3, 4'hF);
    @(negedge clk); gpio_in[16] = 1'b1;
    idle(8);
    check("pre_rst_oe", gpio_oe, 32'hFFFF_FFFF);
    check("pre_rst_irq", 32'(gpio_irq), 32'h1);
    bus_rd(GPIO_OPT, rd_val);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_data_o", data_o, 32'h0);
    check("mid_rst_oe", gpio_oe, 32'h0);
    check("mid_rst_irq", 32'(gpio_irq), 32'h0);
    bus_rd(GPIO_OPT, rd_val); check("mid_rst_opt", rd_val, 32'h0);
    bus_rd(GPIO_OEC, rd_val); check("mid_rst_oec", rd_val, 32'h0);
    bus_rd(GPIO_TAI, rd_val); check("mid_rst_tai", rd_val, 32'h0);
    idle(8);
    check("post_rst_no_irq", 32'(gpio_irq), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
